// File: rtl/tl_sram_responder.sv
// -----------------------------------------------------------------------------
// tl_sram_responder
// TileLink-UL responder that terminates one client port. A-channel requests
// are served from a local word-addressed 64-bit SRAM and answered on the
// D channel. Get, PutFullData and PutPartialData are supported, including
// multi-beat bursts. Hints get a HintAck. Arithmetic/Logic requests,
// out-of-range requests and oversized requests get denied responses.
//
// Ports
//   clock, reset             sole clock; asynchronous active-high reset
//   auto_in_a_*              A channel (request) from the crossbar
//   auto_in_d_*              D channel (response) back to the crossbar
// -----------------------------------------------------------------------------
module tl_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned MAX_SIZE    = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [2:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [2:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LP_LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;

    typedef enum logic [1:0] {S_IDLE, S_PUT, S_READ, S_ACK} state_t;
    // Request class: everything the FSM and datapath need from the opcode.
    typedef enum logic [1:0] {C_PUT, C_GET, C_HINT, C_ATOM} cls_t;

    state_t           r_state, w_state_next;
    cls_t             r_cls, w_in_cls, w_cur_cls;
    logic [3:0]       r_cnt, r_beats_m1, w_in_beats_m1;
    logic [2:0]       r_size, w_cur_size;
    logic [3:0]       r_source, w_cur_source;
    logic             r_denied, w_in_denied, w_cur_denied;
    logic [IDX_W-1:0] r_idx, w_idx, w_beat_idx, w_next_rd_idx;
    logic [31:0]      w_offset;
    logic [32:0]      w_addr_end;
    logic             w_in_range, w_first, w_a_fire, w_a_last, w_wr_en;

    logic             r_d_valid, r_d_denied, r_d_corrupt;
    logic [2:0]       r_d_opcode, r_d_size;
    logic [3:0]       r_d_source;
    logic [63:0]      r_d_data;

    logic [63:0]      r_mem [DEPTH_WORDS];

    // ---------------------------------------------------------------- decode
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_in_cls = C_ATOM;
        case (auto_in_a_bits_opcode)
            3'd0, 3'd1: w_in_cls = C_PUT;
            3'd4:       w_in_cls = C_GET;
            3'd5:       w_in_cls = C_HINT;
            default:    w_in_cls = C_ATOM;   // Arith, Logic, reserved codes
        endcase
    end

    assign w_in_beats_m1 = (auto_in_a_bits_size <= 3'd3) ? 4'd0
                         : 4'((5'd1 << (auto_in_a_bits_size - 3'd3)) - 5'd1);
    assign w_offset      = auto_in_a_bits_address - BASE_ADDR;
    assign w_idx         = w_offset[IDX_W+2:3];
    // 33-bit sum so a request ending exactly at 2^32 cannot wrap into range.
    assign w_addr_end    = {1'b0, auto_in_a_bits_address} + (33'd1 << auto_in_a_bits_size);
    assign w_in_range    = (auto_in_a_bits_address >= BASE_ADDR) && (w_addr_end <= LP_LIMIT)
                        && ({29'd0, auto_in_a_bits_size} <= 32'(MAX_SIZE));
    assign w_in_denied   = !w_in_range || (w_in_cls == C_ATOM);

    // First beat uses the live header; later burst beats use the latched one.
    assign w_first       = (r_state == S_IDLE);
    assign w_cur_cls     = w_first ? w_in_cls              : r_cls;
    assign w_cur_size    = w_first ? auto_in_a_bits_size   : r_size;
    assign w_cur_source  = w_first ? auto_in_a_bits_source : r_source;
    assign w_cur_denied  = w_first ? w_in_denied           : r_denied;
    assign w_beat_idx    = w_first ? w_idx : r_idx + IDX_W'(r_cnt);
    assign w_next_rd_idx = r_idx + IDX_W'(r_cnt) + IDX_W'(1);

    // Only Put and Arith/Logic carry data beats on A; Get and Hint are one beat.
    always_comb begin
        w_a_last = 1'b1;
        if (w_first) begin
            if (w_in_cls == C_PUT || w_in_cls == C_ATOM) w_a_last = (w_in_beats_m1 == 4'd0);
        end else begin
            w_a_last = (r_cnt == r_beats_m1);
        end
    end

    assign w_a_fire = auto_in_a_valid && auto_in_a_ready;
    assign w_wr_en  = w_a_fire && !reset && (w_cur_cls == C_PUT) && !w_cur_denied
                   && !auto_in_a_bits_corrupt;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        auto_in_a_ready = 1'b0;
        case (r_state)
            S_IDLE, S_PUT: begin
                auto_in_a_ready = 1'b1;
                if (auto_in_a_valid) begin
                    if (!w_a_last)                                         w_state_next = S_PUT;
                    else if (w_cur_cls == C_PUT || w_cur_cls == C_HINT)    w_state_next = S_ACK;
                    else                                                   w_state_next = S_READ;
                end
            end
            S_READ: if (auto_in_d_ready && r_cnt == r_beats_m1) w_state_next = S_IDLE;
            S_ACK:  if (auto_in_d_ready)                        w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------ header latch + D regs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cls       <= C_PUT;
            r_size      <= '0;
            r_source    <= '0;
            r_denied    <= 1'b0;
            r_idx       <= '0;
            r_beats_m1  <= '0;
            r_cnt       <= '0;
            r_d_valid   <= 1'b0;
            r_d_opcode  <= '0;
            r_d_size    <= '0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_data    <= '0;
            r_d_corrupt <= 1'b0;
        end else if (w_a_fire) begin
            if (w_first) begin
                r_cls      <= w_in_cls;
                r_size     <= auto_in_a_bits_size;
                r_source   <= auto_in_a_bits_source;
                r_denied   <= w_in_denied;
                r_idx      <= w_idx;
                r_beats_m1 <= w_in_beats_m1;
            end
            r_cnt <= w_a_last ? 4'd0 : r_cnt + 4'd1;
            if (w_a_last) begin
                r_d_valid   <= 1'b1;
                r_d_opcode  <= (w_cur_cls == C_PUT) ? 3'd0 : (w_cur_cls == C_HINT) ? 3'd2 : 3'd1;
                r_d_size    <= w_cur_size;
                r_d_source  <= w_cur_source;
                r_d_denied  <= w_cur_denied;
                r_d_corrupt <= (w_cur_cls == C_GET || w_cur_cls == C_ATOM) && w_cur_denied;
                r_d_data    <= (w_cur_cls == C_GET && !w_cur_denied) ? r_mem[w_beat_idx] : '0;
            end
        end else if (r_state == S_READ && auto_in_d_ready) begin
            if (r_cnt == r_beats_m1) begin
                r_d_valid <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_cnt    <= r_cnt + 4'd1;
                r_d_data <= r_denied ? '0 : r_mem[w_next_rd_idx];
            end
        end else if (r_state == S_ACK && auto_in_d_ready) begin
            r_d_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ SRAM
    // NOTE: the storage array has no reset; only control state is reset, which also lets it map to RAM.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (auto_in_a_bits_mask[i]) r_mem[w_beat_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
            end
        end
    end

    assign auto_in_d_valid        = r_d_valid;
    assign auto_in_d_bits_opcode  = r_d_opcode;
    assign auto_in_d_bits_size    = r_d_size;
    assign auto_in_d_bits_source  = r_d_source;
    assign auto_in_d_bits_denied  = r_d_denied;
    assign auto_in_d_bits_data    = r_d_data;
    assign auto_in_d_bits_corrupt = r_d_corrupt;

    // param and the sub-word / out-of-window address bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{auto_in_a_bits_param, w_offset[31:IDX_W+3], w_offset[2:0]};

endmodule

// File: tb/tb_tl_sram_responder.sv
module tb_tl_sram_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_ready, a_valid;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_corrupt;
    logic        d_ready, d_valid;
    logic [2:0]  d_opcode, d_size;
    logic [3:0]  d_source;
    logic        d_denied, d_corrupt;
    logic [63:0] d_data;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    tl_sram_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        cor;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [63:0] e_data;
        bit          chk_den;
        bit          chk_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr,
                                input logic [7:0] mask, input logic [63:0] data, input logic cor,
                                input logic [2:0] e_op, input logic e_den, input logic e_cor,
                                input logic [63:0] e_data, input bit chk_den, input bit chk_data);
        vec_t v;
        v.op = op; v.size = 3'd3; v.src = src; v.addr = addr; v.mask = mask; v.data = data;
        v.cor = cor; v.e_op = e_op; v.e_den = e_den; v.e_cor = e_cor; v.e_data = e_data;
        v.chk_den = chk_den; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one A beat, waits (bounded) for a_ready, returns at +1 after the accepting edge.
    task automatic send_beat(input string name, input logic [2:0] op, input logic [2:0] size,
                             input logic [3:0] src, input logic [31:0] addr, input logic [7:0] mask,
                             input logic [63:0] data, input logic cor);
        int waited = 0;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
        while (!a_ready && waited < 50) begin
            @(posedge clock); #1; waited++;
        end
        if (!a_ready) begin
            check({name, ".a_ready_timeout"}, a_ready, 1);
            a_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        a_valid = 1'b0;
    endtask

    // Checks the current D beat (bounded wait) and lets it be consumed with d_ready=1.
    task automatic expect_d(input string name, input logic [2:0] op, input logic [2:0] size,
                            input logic [3:0] src, input logic den, input logic cor,
                            input logic [63:0] data, input bit chk_den, input bit chk_data);
        int waited = 0;
        while (!d_valid && waited < 50) begin
            @(posedge clock); #1; waited++;
        end
        check({name, ".d_valid"}, d_valid, 1);
        if (!d_valid) return;
        check({name, ".opcode"}, d_opcode, op);
        check({name, ".size"}, d_size, size);
        check({name, ".source"}, d_source, src);
        check({name, ".corrupt"}, d_corrupt, cor);
        check({name, ".a_ready"}, a_ready, 0);
        if (chk_den)  check({name, ".denied"}, d_denied, den);
        if (chk_data) check({name, ".data"}, d_data, data);
        @(posedge clock); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_words [8];
        int          idx;
        int          cyc;
        logic        dr;

        reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = 3'd7; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0; a_corrupt = 1'b0; d_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst.a_ready", a_ready, 1);
        check("rst.d_valid", d_valid, 0);
        check("rst.d_opcode", d_opcode, 0);
        check("rst.d_data", d_data, 0);
        check("rst.d_denied", d_denied, 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_rst.a_ready", a_ready, 1);

        // ------------------------------------------------ single-beat table
        //            op    src    addr           mask   data                   cor  e_op e_den e_cor e_data             den data
        vecs.push_back(mk(3'd0, 4'd3, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 0, 3'd0, 0, 0, 64'd0,                1, 0));
        vecs.push_back(mk(3'd4, 4'd7, 32'h8000_0010, 8'hFF, 64'd0,                0, 3'd1, 0, 0, 64'h1122334455667788, 1, 1));
        vecs.push_back(mk(3'd0, 4'd1, 32'h8000_0020, 8'hFF, 64'd0,                0, 3'd0, 0, 0, 64'd0,                1, 0));
        vecs.push_back(mk(3'd1, 4'd1, 32'h8000_0020, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 3'd0, 0, 0, 64'd0,             1, 0));
        vecs.push_back(mk(3'd4, 4'd4, 32'h8000_0020, 8'hFF, 64'd0,                0, 3'd1, 0, 0, 64'h0000_0000_FFFF_FFFF, 1, 1));
        vecs.push_back(mk(3'd4, 4'd2, 32'h8000_1000, 8'hFF, 64'd0,                0, 3'd1, 1, 1, 64'd0,                1, 1));
        vecs.push_back(mk(3'd0, 4'd6, 32'h8000_0FF8, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 0, 3'd0, 0, 0, 64'd0,             1, 0));
        vecs.push_back(mk(3'd0, 4'd6, 32'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 3'd0, 1, 0, 64'd0,             1, 0));
        vecs.push_back(mk(3'd4, 4'd8, 32'h8000_0FF8, 8'hFF, 64'd0,                0, 3'd1, 0, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1, 1));
        vecs.push_back(mk(3'd5, 4'd5, 32'h8000_0000, 8'hFF, 64'd0,                0, 3'd2, 0, 0, 64'd0,                0, 0));
        vecs.push_back(mk(3'd2, 4'd9, 32'h8000_0010, 8'hFF, 64'd0,                0, 3'd1, 1, 1, 64'd0,                1, 1));
        vecs.push_back(mk(3'd4, 4'd9, 32'h8000_0010, 8'hFF, 64'd0,                0, 3'd1, 0, 0, 64'h1122334455667788, 1, 1));
        vecs.push_back(mk(3'd0, 4'hC, 32'h8000_0018, 8'hFF, 64'h55,               0, 3'd0, 0, 0, 64'd0,                1, 0));
        vecs.push_back(mk(3'd0, 4'hC, 32'h8000_0018, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 3'd0, 0, 0, 64'd0,             0, 0));
        vecs.push_back(mk(3'd4, 4'hD, 32'h8000_0018, 8'hFF, 64'd0,                0, 3'd1, 0, 0, 64'h55,               1, 1));
        vecs.push_back(mk(3'd0, 4'hE, 32'h8000_1000, 8'hFF, 64'h77,               0, 3'd0, 1, 0, 64'd0,                1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_beat(nm, vecs[i].op, vecs[i].size, vecs[i].src, vecs[i].addr, vecs[i].mask,
                      vecs[i].data, vecs[i].cor);
            check({nm, ".latency"}, d_valid, 1);
            expect_d(nm, vecs[i].e_op, vecs[i].size, vecs[i].src, vecs[i].e_den, vecs[i].e_cor,
                     vecs[i].e_data, vecs[i].chk_den, vecs[i].chk_data);
            check({nm, ".idle_after"}, d_valid, 0);
        end

        // --------------------------------------- 8-beat Put, single AccessAck
        for (int k = 0; k < 8; k++)
            send_beat($sformatf("bput.beat%0d", k), 3'd0, 3'd6, 4'h3, 32'h8000_0040, 8'hFF, 64'h100 + 64'(k), 1'b0);
        check("bput.latency", d_valid, 1);
        expect_d("bput.ack", 3'd0, 3'd6, 4'h3, 1'b0, 1'b0, 64'd0, 1, 0);
        check("bput.single_ack", d_valid, 0);

        // ------------------------------- 8-beat Get with d_ready toggling 1,0
        send_beat("bget", 3'd4, 3'd6, 4'hA, 32'h8000_0040, 8'hFF, 64'd0, 1'b0);
        idx = 0; cyc = 0; dr = 1'b1;
        while (idx < 8 && cyc < 40) begin
            check($sformatf("bget.c%0d.valid", cyc), d_valid, 1);
            check($sformatf("bget.c%0d.data", cyc), d_data, 64'h100 + 64'(idx));
            check($sformatf("bget.c%0d.opcode", cyc), d_opcode, 3'd1);
            check($sformatf("bget.c%0d.source", cyc), d_source, 4'hA);
            check($sformatf("bget.c%0d.a_ready", cyc), a_ready, 0);
            d_ready = dr;
            @(posedge clock); #1;
            if (dr) idx++;
            dr = ~dr;
            cyc++;
        end
        d_ready = 1'b1;
        check("bget.beats", 64'(idx), 64'd8);
        check("bget.done", d_valid, 0);

        // ------------------------- Logic size 4: drain 2 beats, 2 denied beats
        send_beat("logic.b0", 3'd3, 3'd4, 4'h9, 32'h8000_0040, 8'hFF, 64'hFFFF, 1'b0);
        send_beat("logic.b1", 3'd3, 3'd4, 4'h9, 32'h8000_0040, 8'hFF, 64'hFFFF, 1'b0);
        expect_d("logic.d0", 3'd1, 3'd4, 4'h9, 1'b1, 1'b1, 64'd0, 1, 1);
        expect_d("logic.d1", 3'd1, 3'd4, 4'h9, 1'b1, 1'b1, 64'd0, 1, 1);
        send_beat("logic.rb0", 3'd4, 3'd3, 4'h1, 32'h8000_0040, 8'hFF, 64'd0, 1'b0);
        expect_d("logic.rb0", 3'd1, 3'd3, 4'h1, 1'b0, 1'b0, 64'h100, 1, 1);
        send_beat("logic.rb1", 3'd4, 3'd3, 4'h1, 32'h8000_0048, 8'hFF, 64'd0, 1'b0);
        expect_d("logic.rb1", 3'd1, 3'd3, 4'h1, 1'b0, 1'b0, 64'h101, 1, 1);

        // ---------------------------------------------- reset mid-burst Put
        for (int k = 0; k < 8; k++) begin
            send_beat("pre.fill", 3'd0, 3'd6, 4'h2, 32'h8000_0080, 8'hFF, 64'h300 + 64'(k), 1'b0);
            exp_words[k] = 64'h300 + 64'(k);
        end
        expect_d("pre.ack", 3'd0, 3'd6, 4'h2, 1'b0, 1'b0, 64'd0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            send_beat("rstb.beat", 3'd0, 3'd6, 4'h2, 32'h8000_0080, 8'hFF, 64'h200 + 64'(k), 1'b0);
            exp_words[k] = 64'h200 + 64'(k);
        end
        reset = 1'b1;
        #1;
        check("rstb.a_ready", a_ready, 1);
        check("rstb.d_valid", d_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("rstb.post.a_ready", a_ready, 1);
        send_beat("rstb.get", 3'd4, 3'd6, 4'h4, 32'h8000_0080, 8'hFF, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++)
            expect_d($sformatf("rstb.get%0d", k), 3'd1, 3'd6, 4'h4, 1'b0, 1'b0, exp_words[k], 1, 1);
        check("rstb.get.done", d_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
